// File: rtl/ccx_pkg.sv
// Shared widths, request-type encodings and FSM states for the CCX arbiter.
// Combinational only: no latency, no flow control of its own.
package ccx_pkg;

    localparam int CCX_AW = 39;
    localparam int CCX_DW = 64;

    localparam logic RTYPE_INSTR = 1'b0;
    localparam logic RTYPE_DATA  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ccx_state_e;

endpackage

// File: rtl/ccx_arb_sel.sv
// Winner select between instruction and data requesters; combinational, no backpressure.
// CCX_ARB_RR_EN: tie goes to the requester not served last; otherwise data always wins.
module ccx_arb_sel
    import ccx_pkg::*;
(
    input  logic imem_req_i,
    input  logic dmem_req_i,
    input  logic last_i,
    output logic win_o
);

`ifdef CCX_ARB_RR_EN
    always_comb begin
        win_o = RTYPE_INSTR;
        if (imem_req_i && dmem_req_i) begin
            win_o = (last_i == RTYPE_DATA) ? RTYPE_INSTR : RTYPE_DATA;
        end else if (dmem_req_i) begin
            win_o = RTYPE_DATA;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        win_o = RTYPE_INSTR;
        if (dmem_req_i) begin
            win_o = RTYPE_DATA;
        end
    end
`endif

endmodule

// File: rtl/ccx_arbiter.sv
// Merges instruction and data ports onto one downstream channel, one transaction in flight.
// Latency 1 from upstream req to ccx_req; held until ccx_gnt; tie policy via CCX_ARB_RR_EN.
module ccx_arbiter
    import ccx_pkg::*;
#(
    parameter int AW = CCX_AW,
    parameter int DW = CCX_DW
) (
    input  logic          g_clk,
    input  logic          g_reset,

    input  logic          imem_req,
    input  logic [AW-1:0] imem_addr,
    output logic          imem_gnt,
    output logic          imem_err,
    output logic [DW-1:0] imem_rdata,

    input  logic          dmem_req,
    input  logic [AW-1:0] dmem_addr,
    input  logic          dmem_wen,
    input  logic [7:0]    dmem_strb,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dmem_gnt,
    output logic          dmem_err,
    output logic [DW-1:0] dmem_rdata,

    output logic          ccx_req,
    output logic          ccx_rtype,
    output logic [AW-1:0] ccx_addr,
    output logic          ccx_wen,
    output logic [7:0]    ccx_strb,
    output logic [DW-1:0] ccx_wdata,
    input  logic          ccx_gnt,
    input  logic          ccx_err,
    input  logic [DW-1:0] ccx_rdata
);

    ccx_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          rtype_q, rtype_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [7:0]    strb_q, strb_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          win;
    logic          resp_vld;

    ccx_arb_sel u_sel (
        .imem_req_i (imem_req),
        .dmem_req_i (dmem_req),
        .last_i     (last_q),
        .win_o      (win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rtype_d = rtype_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE) begin
            if (imem_req || dmem_req) begin
                state_d = ST_BUSY;
                owner_d = win;
                last_d  = win;
                rtype_d = win;
                if (win == RTYPE_DATA) begin
                    addr_d  = dmem_addr;
                    wen_d   = dmem_wen;
                    strb_d  = dmem_strb;
                    wdata_d = dmem_wdata;
                end else begin
                    addr_d  = imem_addr;
                    wen_d   = 1'b0;
                    strb_d  = '0;
                    wdata_d = '0;
                end
            end
        end else begin
            // Upstream req is ignored here: a dropped req never cancels the downstream beat.
            if (ccx_gnt) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            owner_q <= RTYPE_INSTR;
            last_q  <= RTYPE_INSTR;
            rtype_q <= RTYPE_INSTR;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rtype_q <= rtype_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end

    // Stray grants in IDLE and any grant during reset never reach upstream.
    assign resp_vld   = (state_q == ST_BUSY) && ccx_gnt && !g_reset;

    assign imem_gnt   = resp_vld && (owner_q == RTYPE_INSTR);
    assign imem_err   = imem_gnt && ccx_err;
    assign imem_rdata = imem_gnt ? ccx_rdata : '0;
    assign dmem_gnt   = resp_vld && (owner_q == RTYPE_DATA);
    assign dmem_err   = dmem_gnt && ccx_err;
    assign dmem_rdata = dmem_gnt ? ccx_rdata : '0;

    assign ccx_req    = (state_q == ST_BUSY);
    assign ccx_rtype  = rtype_q;
    assign ccx_addr   = addr_q;
    assign ccx_wen    = wen_q;
    assign ccx_strb   = strb_q;
    assign ccx_wdata  = wdata_q;

endmodule

// File: tb/tb_ccx_arbiter.sv
// Scenario bench for ccx_arbiter: expected downstream beats and responses queued at drive time.
module tb_ccx_arbiter;

    localparam int AW = 39;
    localparam int DW = 64;

    logic          g_clk;
    logic          g_reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_err;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req;
    logic [AW-1:0] dmem_addr;
    logic          dmem_wen;
    logic [7:0]    dmem_strb;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_gnt;
    logic          dmem_err;
    logic [DW-1:0] dmem_rdata;
    logic          ccx_req;
    logic          ccx_rtype;
    logic [AW-1:0] ccx_addr;
    logic          ccx_wen;
    logic [7:0]    ccx_strb;
    logic [DW-1:0] ccx_wdata;
    logic          ccx_gnt;
    logic          ccx_err;
    logic [DW-1:0] ccx_rdata;

    ccx_arbiter #(.AW(AW), .DW(DW)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_err   (imem_err),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_addr  (dmem_addr),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_err   (dmem_err),
        .dmem_rdata (dmem_rdata),
        .ccx_req    (ccx_req),
        .ccx_rtype  (ccx_rtype),
        .ccx_addr   (ccx_addr),
        .ccx_wen    (ccx_wen),
        .ccx_strb   (ccx_strb),
        .ccx_wdata  (ccx_wdata),
        .ccx_gnt    (ccx_gnt),
        .ccx_err    (ccx_err),
        .ccx_rdata  (ccx_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic          rtype;
        logic [AW-1:0] addr;
        logic          wen;
        logic [7:0]    strb;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic push_instr(input logic [AW-1:0] a, input logic [DW-1:0] rd, input logic e);
        exp_t x;
        x.rtype = 1'b0; x.addr = a; x.wen = 1'b0; x.strb = 8'h00; x.wdata = '0;
        x.rdata = rd; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic push_data(input logic [AW-1:0] a, input logic w, input logic [7:0] s,
                             input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic e);
        exp_t x;
        x.rtype = 1'b1; x.addr = a; x.wen = w; x.strb = s; x.wdata = wd;
        x.rdata = rd; x.err = e;
        exp_q.push_back(x);
    endtask

    // Waits for ccx_req, checks the beat against the queue head, holds it `delay` cycles,
    // then grants; drop[0]/drop[1] release imem_req/dmem_req in the grant cycle.
    task automatic serve(input int delay, input logic [1:0] drop);
        exp_t x;
        int waited;
        logic [AW+DW+9:0] exp_pl;
        logic [2*DW+3:0]  exp_rsp;
        waited = 0;
        while (ccx_req !== 1'b1 && waited < 20) begin
            @(negedge g_clk);
            waited++;
        end
        n_tests++;
        if (ccx_req !== 1'b1) begin
            n_fail++;
            $display("FAIL serve_wait ccx_req=%b required 1", ccx_req);
            return;
        end
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty size=0 required >0");
            return;
        end
        x = exp_q.pop_front();
        exp_pl = {x.rtype, x.addr, x.wen, x.strb, x.wdata};
        n_tests++;
        if ({ccx_rtype, ccx_addr, ccx_wen, ccx_strb, ccx_wdata} !== exp_pl) begin
            n_fail++;
            $display("FAIL payload rtype=%b addr=%h wen=%b strb=%h wdata=%h required rtype=%b addr=%h wen=%b strb=%h wdata=%h",
                     ccx_rtype, ccx_addr, ccx_wen, ccx_strb, ccx_wdata,
                     x.rtype, x.addr, x.wen, x.strb, x.wdata);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge g_clk);
            n_tests++;
            if (ccx_req !== 1'b1 || {ccx_rtype, ccx_addr, ccx_wen, ccx_strb, ccx_wdata} !== exp_pl
                || imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cycle=%0d req=%b addr=%h igrant=%b dgrant=%b required req=1 addr=%h grants=0",
                         i, ccx_req, ccx_addr, imem_gnt, dmem_gnt, x.addr);
            end
        end
        ccx_gnt   = 1'b1;
        ccx_rdata = x.rdata;
        ccx_err   = x.err;
        if (drop[0]) imem_req = 1'b0;
        if (drop[1]) dmem_req = 1'b0;
        #1;
        exp_rsp = {!x.rtype, !x.rtype && x.err, x.rtype ? {DW{1'b0}} : x.rdata,
                    x.rtype,  x.rtype && x.err, x.rtype ? x.rdata : {DW{1'b0}}};
        n_tests++;
        if ({imem_gnt, imem_err, imem_rdata, dmem_gnt, dmem_err, dmem_rdata} !== exp_rsp) begin
            n_fail++;
            $display("FAIL response i=%b/%b/%h d=%b/%b/%h required i=%b/%b/%h d=%b/%b/%h",
                     imem_gnt, imem_err, imem_rdata, dmem_gnt, dmem_err, dmem_rdata,
                     exp_rsp[2*DW+3], exp_rsp[2*DW+2], exp_rsp[2*DW+1:DW+2],
                     exp_rsp[DW+1], exp_rsp[DW], exp_rsp[DW-1:0]);
        end
        @(negedge g_clk);
        ccx_gnt   = 1'b0;
        ccx_rdata = '0;
        ccx_err   = 1'b0;
        #1;
        n_tests++;
        if (ccx_req !== 1'b0 || imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gap req=%b igrant=%b dgrant=%b required 0 0 0",
                     ccx_req, imem_gnt, dmem_gnt);
        end
    endtask

    task automatic test_reset();
        g_reset = 1'b1;
        imem_req = 1'b0; imem_addr = '0;
        dmem_req = 1'b0; dmem_addr = '0; dmem_wen = 1'b0; dmem_strb = '0; dmem_wdata = '0;
        ccx_gnt = 1'b1; ccx_err = 1'b1; ccx_rdata = 64'h1234;
        repeat (2) @(negedge g_clk);
        n_tests++;
        if ({ccx_req, ccx_rtype, ccx_addr, ccx_wen, ccx_strb, ccx_wdata} !== '0
            || imem_gnt !== 1'b0 || dmem_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state req=%b rtype=%b addr=%h wen=%b strb=%h wdata=%h ig=%b dg=%b required all 0",
                     ccx_req, ccx_rtype, ccx_addr, ccx_wen, ccx_strb, ccx_wdata, imem_gnt, dmem_gnt);
        end
        ccx_gnt = 1'b0; ccx_err = 1'b0; ccx_rdata = '0;
        g_reset = 1'b0;
        @(negedge g_clk);
    endtask

    task automatic test_single_fetch();
        imem_req  = 1'b1;
        imem_addr = 39'h1000;
        push_instr(39'h1000, 64'hDEADBEEF_00000013, 1'b0);
        @(negedge g_clk);
        n_tests++;
        if (ccx_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_latency ccx_req=%b required 1", ccx_req);
        end
        serve(3, 2'b01);
    endtask

    task automatic test_tie();
        imem_req = 1'b1; imem_addr = 39'h3000;
        dmem_req = 1'b1; dmem_addr = 39'h2000; dmem_wen = 1'b1;
        dmem_strb = 8'h0F; dmem_wdata = 64'h1122_3344_5566_7788;
        push_data(39'h2000, 1'b1, 8'h0F, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
        push_instr(39'h3000, 64'hCAFE_0001, 1'b0);
        serve(1, 2'b10);
        @(negedge g_clk);
        n_tests++;
        if (ccx_req !== 1'b1 || ccx_rtype !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second req=%b rtype=%b required 1 0", ccx_req, ccx_rtype);
        end
        serve(0, 2'b01);
    endtask

    task automatic test_continuous_ties();
        imem_req = 1'b1; imem_addr = 39'h4000;
        dmem_req = 1'b1; dmem_addr = 39'h5000; dmem_wen = 1'b0;
        dmem_strb = 8'hFF; dmem_wdata = 64'h0;
`ifdef CCX_ARB_RR_EN
        push_data (39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA0, 1'b0);
        push_instr(39'h4000, 64'hA1, 1'b0);
        push_data (39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA2, 1'b0);
        push_instr(39'h4000, 64'hA3, 1'b0);
`else
        push_data(39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA0, 1'b0);
        push_data(39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA1, 1'b0);
        push_data(39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA2, 1'b0);
        push_data(39'h5000, 1'b0, 8'hFF, 64'h0, 64'hA3, 1'b0);
`endif
        for (int t = 0; t < 4; t++) begin
            serve(t % 3, (t == 3) ? 2'b11 : 2'b00);
        end
    endtask

    task automatic test_error();
        dmem_req = 1'b1; dmem_addr = 39'h6000; dmem_wen = 1'b0;
        dmem_strb = 8'hFF; dmem_wdata = 64'hAAAA;
        push_data(39'h6000, 1'b0, 8'hFF, 64'hAAAA, 64'h55, 1'b1);
        serve(2, 2'b10);
    endtask

    task automatic test_reset_busy();
        imem_req = 1'b1; imem_addr = 39'h7000;
        @(negedge g_clk);
        n_tests++;
        if (ccx_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rbusy_start ccx_req=%b required 1", ccx_req);
        end
        imem_req = 1'b0;
        g_reset  = 1'b1;
        @(negedge g_clk);
        n_tests++;
        if (ccx_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rbusy_req ccx_req=%b required 0", ccx_req);
        end
        g_reset = 1'b0;
        ccx_gnt = 1'b1; ccx_rdata = 64'h99; ccx_err = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (imem_gnt !== 1'b0 || dmem_gnt !== 1'b0 || ccx_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rbusy_stray cycle=%0d ig=%b dg=%b req=%b required 0 0 0",
                         i, imem_gnt, dmem_gnt, ccx_req);
            end
            @(negedge g_clk);
        end
        ccx_gnt = 1'b0; ccx_rdata = '0; ccx_err = 1'b0;
        imem_req = 1'b1; imem_addr = 39'h8000;
        push_instr(39'h8000, 64'h77, 1'b0);
        serve(1, 2'b01);
    endtask

    task automatic test_stray_idle();
        ccx_gnt = 1'b1; ccx_rdata = 64'hFFFF; ccx_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            n_tests++;
            if (imem_gnt !== 1'b0 || dmem_gnt !== 1'b0 || ccx_req !== 1'b0
                || imem_rdata !== '0 || dmem_rdata !== '0 || imem_err !== 1'b0 || dmem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stray cycle=%0d ig=%b dg=%b req=%b ird=%h drd=%h required all 0",
                         i, imem_gnt, dmem_gnt, ccx_req, imem_rdata, dmem_rdata);
            end
        end
        ccx_gnt = 1'b0; ccx_rdata = '0; ccx_err = 1'b0;
        @(negedge g_clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie();
        test_continuous_ties();
        test_error();
        test_stray_idle();
        test_reset_busy();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ccx_arbiter.md
CCX_ARBITER -- requirements
Module: ccx_arbiter

Interface
REQ-001 SHALL have parameter AW, default 39, memory address width.
REQ-002 SHALL have parameter DW, default 64, data width.
REQ-003 SHALL have port g_clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port g_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports imem_req input 1, imem_addr input AW: instruction fetch request and address (read-only).
REQ-006 SHALL have ports imem_gnt output 1, imem_err output 1, imem_rdata output DW: instruction response.
REQ-007 SHALL have ports dmem_req input 1, dmem_addr input AW, dmem_wen input 1, dmem_strb input 8, dmem_wdata input DW: data request.
REQ-008 SHALL have ports dmem_gnt output 1, dmem_err output 1, dmem_rdata output DW: data response.
REQ-009 SHALL have ports ccx_req output 1, ccx_rtype output 1 (0=instr, 1=data), ccx_addr output AW, ccx_wen output 1, ccx_strb output 8, ccx_wdata output DW: merged downstream request.
REQ-010 SHALL have ports ccx_gnt input 1, ccx_err input 1, ccx_rdata input DW: downstream response, valid in the ccx_gnt cycle.

Function
REQ-011 SHALL implement a two-state FSM, IDLE and BUSY, with one outstanding downstream transaction at most.
REQ-012 In IDLE with at least one upstream req high, SHALL pick a winner, register its payload onto ccx_* outputs, record owner, and enter BUSY; ccx_req rises the cycle after the upstream req is sampled (latency 1).
REQ-013 For an imem win, SHALL drive ccx_rtype=0, ccx_wen=0, ccx_strb=0, ccx_wdata=0; for a dmem win, ccx_rtype=1 and dmem payload verbatim.
REQ-014 In BUSY, SHALL hold ccx_req=1 and all ccx_* payload stable until ccx_gnt.
REQ-015 On ccx_gnt in BUSY, SHALL pulse the owner's gnt for that same cycle with err/rdata passed through combinationally, then enter IDLE with ccx_req=0 next cycle.
REQ-016 Non-owner gnt SHALL be 0 always; non-owner rdata/err SHALL be 0.
REQ-017 A requester whose gnt has pulsed MAY hold req high for a new request; it SHALL be arbitrated in the following IDLE cycle (minimum one idle cycle between downstream transactions).
REQ-018 ccx_gnt while IDLE (stray) SHALL be ignored: no upstream gnt, no state change.
REQ-019 Upstream req dropping while BUSY SHALL NOT cancel the registered downstream transaction; its response is still routed to the owner.
REQ-020 Simultaneous imem_req and dmem_req in IDLE SHALL resolve per REQ-024/REQ-025.

Reset
REQ-021 While g_reset is high at a clock edge, SHALL enter IDLE, owner=instr, last-served=instr, ccx_req=0, ccx_rtype=0, ccx_addr/strb/wdata=0, ccx_wen=0.
REQ-022 Reset mid-BUSY SHALL abandon the transaction; a ccx_gnt arriving afterwards is stray per REQ-018.
REQ-023 imem_gnt/dmem_gnt SHALL be 0 during reset.

Configuration
REQ-024 Without CCX_ARB_RR_EN: fixed priority, dmem always wins a tie.
REQ-025 With CCX_ARB_RR_EN: on a tie, the requester not served last wins; last-served updates on every grant decision.

Structure
REQ-026 Package ccx_pkg SHALL hold AW/DW defaults, rtype constants (RTYPE_INSTR=0, RTYPE_DATA=1) and FSM state encoding.
REQ-027 Winner selection SHALL be a combinational sub-module ccx_arb_sel (inputs: two reqs, last-served; output: winner).

Verification
REQ-028 Single fetch: imem_req=1, imem_addr=0x1000, ccx_gnt 3 cycles after ccx_req with rdata=0xDEADBEEF_00000013 -> ccx_rtype=0, ccx_addr=0x1000, imem_gnt one cycle with that rdata, dmem_gnt=0.
REQ-029 Tie: both req same cycle, dmem_wen=1, addr 0x2000, strb=0x0F -> data served first (ccx_rtype=1, ccx_wen=1, ccx_strb=0x0F), instr next after one idle cycle.
REQ-030 Continuous ties, 4 transactions: without CCX_ARB_RR_EN -> D,D,D,D; with it -> D,I,D,I.
REQ-031 Error: dmem read, ccx_gnt with ccx_err=1 -> dmem_gnt=1, dmem_err=1, imem_err=0.
REQ-032 Reset asserted while BUSY, then ccx_gnt=1 -> ccx_req=0 after reset edge, no upstream gnt, FSM IDLE.
REQ-033 Stray ccx_gnt=1 in IDLE with no requests -> no upstream gnt, ccx_req stays 0.
